tc3_gf2_mul_seq: RTL
====================

// Module: tc3_gf2_mul_seq
// PURPOSE
//  Parametrised digit-serial 3-way split GF(2)[x] (carry-less) multiplier, c = a*b.
//  Splits each N-bit operand into three K=N/3 limbs and runs all limb sub-products in parallel, D bits/cycle.
//  Adds a start/busy/done handshake and a one-cycle recombination stage.
//  Used by field-arithmetic datapaths (binary ECC, PQC) beside the fixed-size multipliers.
// PARAMETERS
//  N  384  operand width in bits; must be a multiple of 3
//  D  1    digit size: multiplier bits consumed per cycle per engine; must divide K=N/3
// PORTS
//  clk    in   1    rising-edge clock
//  rst    in   1    synchronous reset, active-high
//  start  in   1    request; a/b sampled on the accepting edge
//  a      in   N    operand A (bit i = coeff of x^i)
//  b      in   N    operand B
//  busy   out  1    high while an operation is in flight
//  done   out  1    one-cycle pulse: c valid
//  c      out  2N   product; bit 2N-1 always 0
// BEHAVIOUR
//  - Reset: one clock edge with rst=1 -> state IDLE; busy=0, done=0, c=0; engine accumulators and counters cleared.
//    rst overrides every other input and is honoured mid-operation; the in-flight result is discarded.
//  - Limbs: a0=a[K-1:0], a1=a[2K-1:K], a2=a[3K-1:2K] (b likewise). Operands are latched on accept.
//    Later changes on a/b do not affect the result.
//  - FSM IDLE -> RUN -> COMB -> IDLE.
//    IDLE: start=1 accepts; busy=1 from the next cycle.
//    RUN: digit counter 0..K/D-1. Each engine XORs (y << j*D+i) into its acc for every set bit i of the current x digit.
//      Last digit -> COMB.
//    COMB: c <= recombination (below). done=1 on the following cycle; state is IDLE in that cycle.
//  - Latency: done is high on edge t+K/D+2 for start sampled on edge t (N=384, D=1: 130; D=8: 18).
//  - start while busy=1 is ignored (no queuing). start in the done cycle is accepted (back-to-back, period K/D+2).
//  - c holds its value until the next COMB writes it. done is never high for two consecutive cycles.
//  - Each engine acc is 2K-1 bits; no truncation anywhere.
//  - Recombination (all XOR): c = P00 ^ (X1<<K) ^ (X2<<2K) ^ (X3<<3K) ^ (P22<<4K)
//    X1 = a0b1+a1b0, X2 = a0b2+a1b1+a2b0, X3 = a1b2+a2b1
// CONFIGURATION
//  TC3_KARATSUBA_EN defined: 6 engines: P00, P11, P22, Q01=(a0+a1)(b0+b1), Q02=(a0+a2)(b0+b2), Q12=(a1+a2)(b1+b2).
//    X1=Q01^P00^P11, X2=Q02^P00^P22^P11, X3=Q12^P11^P22.
//  TC3_KARATSUBA_EN undefined: 9 schoolbook engines (every aibj), Xk as XOR of the cross products.
//  Results, latency and handshake are identical in both builds.
// STRUCTURE
//  - Package tc3_pkg holds:
//    state enum {IDLE, RUN, COMB};
//    localparams K=N/3, NDIG=K/D, CW=$clog2(NDIG+1);
//    elaboration check that N%3==0 and K%D==0 (fatal otherwise).
//  - Sub-module gf2_digit_mul #(K,D) (instantiated 6x or 9x) holds:
//    clr/en inputs, x/y limbs, digit index, 2K-1 bit acc output.
//  - The top holds the FSM, digit counter, operand latches, the pre-add XORs and the recombination register.
// TESTING
//  1. N=384,D=1: a=1, b=1, start one cycle -> done at edge 130, c=1, busy high 129 cycles.
//  2. a=3, b=3 -> c=5; a=1<<383, b=1<<383 -> only c[766]=1 (top-limb, highest-shift path).
//  3. a=b=all ones -> c equals the software clmul model. With D=8 the same vector gives done at edge 18.
//  4. start pulsed at cycles 5 and 60 of a run -> ignored; one done, c from the first operands.
//     start in the done cycle -> second done exactly 130 cycles later.
//  5. rst=1 at RUN cycle 50 -> next cycle busy=0, c=0, no done; a new start then completes normally.
//  6. 1000 random vectors, N in {384,96,12}, D in {1,4}, TC3_KARATSUBA_EN on and off -> all match the clmul model.

Source files
------------

// File: rtl/tc3_pkg.sv
// Purpose: shared types and sizing helpers for the 3-way split GF(2)[x] multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum; helpers deriving limb width K=N/3, digit count NDIG=K/D,
// digit counter width CW=$clog2(NDIG+1), and a legality test for (N, D).
package tc3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COMB = 2'd2
    } state_t;

    // Limb width K = N/3
    function automatic int calc_k(input int n);
        return n / 3;
    endfunction

    // Number of digits per limb, NDIG = K/D
    function automatic int calc_ndig(input int n, input int d);
        return (n / 3) / d;
    endfunction

    // Digit counter width, CW = $clog2(NDIG+1)
    function automatic int calc_cw(input int n, input int d);
        return $clog2(((n / 3) / d) + 1);
    endfunction

    // N must split into three equal limbs and D must tile a limb exactly
    function automatic bit cfg_ok(input int n, input int d);
        return (n > 0) && (n % 3 == 0) && (d > 0) && ((n / 3) % d == 0);
    endfunction

endpackage

// File: rtl/tc3_gf2_mul_seq_engine.sv
// Purpose: digit-serial carry-less limb multiplier, acc ^= y << (dig*D+i) for each set bit i of x's current digit.
// Latency: one digit per enabled cycle, K/D cycles per limb product.
// Backpressure: none; advances only when en=1, clr has priority and zeroes acc.
//
// Ports: clk; clr (sync clear); en (consume digit 'dig'); x, y (K-bit limbs, held stable
// for the whole product); dig (digit index); acc (2K-1 bit partial/complete product).
module gf2_digit_mul
    import tc3_pkg::*;
#(
    parameter int K = 128,
    parameter int D = 1,
    localparam int CW = calc_cw(3 * K, D)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic [K-1:0]    x,
    input  logic [K-1:0]    y,
    input  logic [CW-1:0]   dig,
    output logic [2*K-2:0]  acc
);

    localparam int AW = 2 * K - 1;

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] y_ext;
    logic [D-1:0]  x_dig;
    logic [31:0]   base;

    always_comb begin
        base  = 32'(dig) * 32'(D);
        x_dig = D'(x >> base);
        y_ext = AW'(y);
        acc_d = acc_q;
        // Highest shift is K-1 on a K-bit y, so AW=2K-1 bits never truncate.
        for (int i = 0; i < D; i++) begin
            if (x_dig[i]) begin
                acc_d = acc_d ^ (y_ext << (base + 32'(i)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/tc3_gf2_mul_seq.sv
// Purpose: 3-way split digit-serial GF(2)[x] multiplier c = a*b with start/busy/done handshake.
// Latency: done sampled high on edge t+N/3/D+2 after start sampled on edge t; back-to-back period N/3/D+2.
// Backpressure: start is ignored while busy=1 (no queuing); start in the done cycle is accepted.
//
// Ports: clk; rst (sync, active-high); start; a, b (N-bit operands, bit i = coeff of x^i);
// busy (operation in flight); done (one-cycle result strobe); c (2N-bit product, held until next result).
// Build option TC3_KARATSUBA_EN: 6 Karatsuba-style engines instead of 9 schoolbook engines;
// results and timing are identical either way.
module tc3_gf2_mul_seq
    import tc3_pkg::*;
#(
    parameter int N = 384,
    parameter int D = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    output logic            busy,
    output logic            done,
    output logic [2*N-1:0]  c
);

    localparam int K    = calc_k(N);
    localparam int NDIG = calc_ndig(N, D);
    localparam int CW   = calc_cw(N, D);
    localparam int AW   = 2 * K - 1;
    localparam int W    = 2 * N;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);
`ifdef TC3_KARATSUBA_EN
    localparam int NENG = 6;
`else
    localparam int NENG = 9;
`endif

    generate
        if (!cfg_ok(N, D)) begin : g_cfg_err
            $fatal(1, "tc3_gf2_mul_seq: N must be a multiple of 3 and D must divide N/3");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    c_q, c_d, c_rec;
    logic            done_q, done_d;
    logic            acc_clr, acc_en, eng_clr;

    logic [K-1:0]    la [3];
    logic [K-1:0]    lb [3];
    logic [K-1:0]    eng_x [NENG];
    logic [K-1:0]    eng_y [NENG];
    logic [AW-1:0]   eng_acc [NENG];
    logic [AW-1:0]   p00, p22, x1, x2, x3;

    // Limbs come from the latched operands so later changes on a/b are invisible.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            la[i] = a_q[i*K +: K];
            lb[i] = b_q[i*K +: K];
        end
    end

    // Engine operand selection, including the pre-add XORs of the Karatsuba build.
    always_comb begin
        for (int e = 0; e < NENG; e++) begin
            eng_x[e] = '0;
            eng_y[e] = '0;
        end
`ifdef TC3_KARATSUBA_EN
        // 0:P00 1:P11 2:P22 3:Q01 4:Q02 5:Q12
        eng_x[0] = la[0];          eng_y[0] = lb[0];
        eng_x[1] = la[1];          eng_y[1] = lb[1];
        eng_x[2] = la[2];          eng_y[2] = lb[2];
        eng_x[3] = la[0] ^ la[1];  eng_y[3] = lb[0] ^ lb[1];
        eng_x[4] = la[0] ^ la[2];  eng_y[4] = lb[0] ^ lb[2];
        eng_x[5] = la[1] ^ la[2];  eng_y[5] = lb[1] ^ lb[2];
`else
        // Engine 3*i+j computes ai*bj
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                eng_x[3*i+j] = la[i];
                eng_y[3*i+j] = lb[j];
            end
        end
`endif
    end

    // Accumulators clear on accept so they start from zero in the first RUN cycle.
    assign eng_clr = rst | acc_clr;

    generate
        for (genvar g = 0; g < NENG; g++) begin : g_eng
            gf2_digit_mul #(
                .K (K),
                .D (D)
            ) u_eng (
                .clk (clk),
                .clr (eng_clr),
                .en  (acc_en),
                .x   (eng_x[g]),
                .y   (eng_y[g]),
                .dig (cnt_q),
                .acc (eng_acc[g])
            );
        end
    endgenerate

    function automatic logic [W-1:0] ext(input logic [AW-1:0] p);
        return {{(W-AW){1'b0}}, p};
    endfunction

    // Middle coefficients X1..X3 from the engine outputs, then shift-and-XOR into 2N bits.
    always_comb begin
        p00 = eng_acc[0];
`ifdef TC3_KARATSUBA_EN
        p22 = eng_acc[2];
        x1  = eng_acc[3] ^ eng_acc[0] ^ eng_acc[1];
        x2  = eng_acc[4] ^ eng_acc[0] ^ eng_acc[2] ^ eng_acc[1];
        x3  = eng_acc[5] ^ eng_acc[1] ^ eng_acc[2];
`else
        p22 = eng_acc[8];
        x1  = eng_acc[1] ^ eng_acc[3];
        x2  = eng_acc[2] ^ eng_acc[4] ^ eng_acc[6];
        x3  = eng_acc[5] ^ eng_acc[7];
`endif
        c_rec = ext(p00)
              ^ (ext(x1)  << K)
              ^ (ext(x2)  << (2 * K))
              ^ (ext(x3)  << (3 * K))
              ^ (ext(p22) << (4 * K));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        done_d  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    acc_clr = 1'b1;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                if (cnt_q == LAST_DIG) begin
                    state_d = COMB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMB: begin
                c_d     = c_rec;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign c    = c_q;

endmodule
